// File: rtl/suspect_string_rr_arbiter.sv
// Round-robin arbiter that serialises per-size suspect strings from the Bloom
// engines onto a single valid/ready stream with a one-entry output register.
module suspect_string_rr_arbiter #(
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned MAX_STR_SIZE   = 20,
  parameter int unsigned MIN_STR_SIZE   = 3,
  parameter int unsigned MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1
) (
  input  logic                                                     clk_i,
  input  logic                                                     srst_i,
  input  logic [MAX_STR_SIZE:MIN_STR_SIZE][MAX_STR_SIZE-1:0][BYTE_W-1:0] suspect_strings_data_i,
  input  logic [MAX_STR_SIZE:MIN_STR_SIZE]                         suspect_strings_valid_i,
  output logic [MAX_STR_SIZE:MIN_STR_SIZE]                         suspect_strings_ready_o,
  output logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]                      str_data_o,
  output logic [MAX_STR_SIZE_W-1:0]                                str_size_o,
  output logic                                                     str_valid_o,
  input  logic                                                     str_ready_i,
  output logic                                                     arb_busy_o
);

  typedef logic [MAX_STR_SIZE_W-1:0] size_t;
  typedef enum logic {EMPTY, FULL} state_t;

  localparam size_t MIN_SZ = size_t'(MIN_STR_SIZE);
  localparam size_t MAX_SZ = size_t'(MAX_STR_SIZE);

  state_t state;
  size_t  ptr;
  size_t  grant;
  logic   grant_vld;
  logic   load_en;
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] load_data;

  assign str_valid_o = (state == FULL);
  assign load_en     = !str_valid_o || str_ready_i;
  assign arb_busy_o  = str_valid_o || (|suspect_strings_valid_i);

  // First pass covers [ptr..MAX], second pass wraps to [MIN..ptr-1].
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (load_en && !srst_i) begin
      for (int unsigned n = MIN_STR_SIZE; n <= MAX_STR_SIZE; n++) begin
        if (!grant_vld && suspect_strings_valid_i[n] && (size_t'(n) >= ptr)) begin
          grant_vld = 1'b1;
          grant     = size_t'(n);
        end
      end
      for (int unsigned n = MIN_STR_SIZE; n <= MAX_STR_SIZE; n++) begin
        if (!grant_vld && suspect_strings_valid_i[n]) begin
          grant_vld = 1'b1;
          grant     = size_t'(n);
        end
      end
    end
  end

  always_comb begin
    suspect_strings_ready_o = '0;
    for (int unsigned n = MIN_STR_SIZE; n <= MAX_STR_SIZE; n++) begin
      suspect_strings_ready_o[n] = grant_vld && (grant == size_t'(n));
    end
  end

  // Bytes at or above the string length are masked to zero on capture.
  always_comb begin
    load_data = '0;
    for (int unsigned n = MIN_STR_SIZE; n <= MAX_STR_SIZE; n++) begin
      if (grant_vld && (grant == size_t'(n))) begin
        for (int unsigned b = 0; b < MAX_STR_SIZE; b++) begin
          load_data[b] = suspect_strings_data_i[n][b] & {BYTE_W{b < n}};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= EMPTY;
      str_data_o <= '0;
      str_size_o <= '0;
      ptr        <= MIN_SZ;
    end else if (grant_vld) begin
      state      <= FULL;
      str_data_o <= load_data;
      str_size_o <= grant;
      ptr        <= (grant == MAX_SZ) ? MIN_SZ : grant + size_t'(1);
    end else if (load_en) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_suspect_string_rr_arbiter.sv
// Self-checking bench for suspect_string_rr_arbiter: directed table, hand
// sequences for wrap/hold/reset, and randomized traffic against a queue model.
module tb_suspect_string_rr_arbiter;

  localparam int MIN = 3;
  localparam int MAX = 20;
  localparam int N   = MAX - MIN + 1;
  localparam int SW  = $clog2(MAX) + 1;

  logic                               clk = 1'b0;
  logic                               srst;
  logic [MAX:MIN][MAX-1:0][7:0]       data_in;
  logic [MAX:MIN]                     valid;
  logic [MAX:MIN]                     ready;
  logic [MAX-1:0][7:0]                str_data;
  logic [SW-1:0]                      str_size;
  logic                               str_valid;
  logic                               str_ready;
  logic                               busy;

  int checks = 0;
  int errors = 0;

  suspect_string_rr_arbiter #(
    .BYTE_W(8),
    .MAX_STR_SIZE(MAX),
    .MIN_STR_SIZE(MIN),
    .MAX_STR_SIZE_W(SW)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .suspect_strings_data_i(data_in),
    .suspect_strings_valid_i(valid),
    .suspect_strings_ready_o(ready),
    .str_data_o(str_data),
    .str_size_o(str_size),
    .str_valid_o(str_valid),
    .str_ready_i(str_ready),
    .arb_busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MAX:MIN] valid;
    logic           sready;
    logic [MAX:MIN] exp_ready;
    logic           exp_ovalid;
    int             exp_size;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MAX:MIN] m(input int a, input int b = 0);
    logic [MAX:MIN] r;
    r = '0;
    if (a >= MIN && a <= MAX) r[a] = 1'b1;
    if (b >= MIN && b <= MAX) r[b] = 1'b1;
    return r;
  endfunction

  // Expected output word for requester g: its first g bytes, rest zero.
  function automatic logic [159:0] padded(input int g);
    logic [159:0] r;
    r = '0;
    for (int b = 0; b < MAX; b++)
      if (b < g) r[b*8 +: 8] = data_in[g][b];
    return r;
  endfunction

  task automatic fill_pattern();
    for (int n = MIN; n <= MAX; n++)
      for (int b = 0; b < MAX; b++)
        data_in[n][b] = 8'h80 | 8'(n * 5 + b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; valid = '0; str_ready = 1'b0;
    tick();
    srst = 1'b0;
  endtask

  // Random-phase model state
  int          m_ptr;
  logic        m_valid;
  int          m_size;
  logic [159:0] m_data;
  bit          pend [MAX:MIN];
  int          waits [MAX:MIN];

  initial begin
    srst = 1'b1; valid = '1; str_ready = 1'b0;
    fill_pattern();
    tick(); tick();
    #1;
    check("reset_ready", 160'(ready), 160'(0));
    check("reset_valid", 160'(str_valid), 160'(0));
    check("reset_size", 160'(str_size), 160'(0));
    check("reset_data", 160'(str_data), 160'(0));
    valid = '0; srst = 1'b0;
    tick();

    // Single string "abcde" on requester 5
    data_in[5][0] = "a"; data_in[5][1] = "b"; data_in[5][2] = "c";
    data_in[5][3] = "d"; data_in[5][4] = "e";
    valid = m(5); str_ready = 1'b1;
    #1 check("abcde_ready", 160'(ready), 160'(m(5)));
    tick();
    valid = '0;
    #1;
    check("abcde_valid", 160'(str_valid), 160'(1));
    check("abcde_size", 160'(str_size), 160'(5));
    check("abcde_data", 160'(str_data), 160'h65_64_63_62_61);
    check("abcde_busy", 160'(busy), 160'(1));
    tick();
    #1 check("abcde_empty", 160'(str_valid), 160'(0));
    check("idle_busy", 160'(busy), 160'(0));
    fill_pattern();

    // Table: output hold with 7/12, then pointer wrap 19 -> 20 -> 3
    tbl[0] = '{m(7, 12), 1'b0, m(7), 1'b0, 0};
    for (int i = 1; i <= 10; i++) tbl[i] = '{m(12), 1'b0, m(0), 1'b1, 7};
    tbl[11] = '{m(12), 1'b1, m(12), 1'b1, 7};
    tbl[12] = '{m(0), 1'b1, m(0), 1'b1, 12};
    tbl[13] = '{m(0), 1'b1, m(0), 1'b0, 0};
    tbl[14] = '{m(19), 1'b1, m(19), 1'b0, 0};
    tbl[15] = '{m(3, 20), 1'b1, m(20), 1'b1, 19};
    tbl[16] = '{m(3), 1'b1, m(3), 1'b1, 20};
    tbl[17] = '{m(0), 1'b1, m(0), 1'b1, 3};
    tbl[18] = '{m(0), 1'b1, m(0), 1'b0, 0};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      valid = tbl[i].valid; str_ready = tbl[i].sready;
      #1;
      check($sformatf("tbl%0d_ready", i), 160'(ready), 160'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_ovalid", i), 160'(str_valid), 160'(tbl[i].exp_ovalid));
      if (tbl[i].exp_ovalid) begin
        check($sformatf("tbl%0d_size", i), 160'(str_size), 160'(tbl[i].exp_size));
        check($sformatf("tbl%0d_data", i), 160'(str_data), padded(tbl[i].exp_size));
      end
      tick();
    end

    // All requesters valid: strict rotation, one string per cycle
    do_reset();
    valid = '1; str_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      #1;
      check($sformatf("rr%0d_ready", k), 160'(ready), 160'(m(MIN + k % N)));
      if (k > 0) begin
        check($sformatf("rr%0d_ovalid", k), 160'(str_valid), 160'(1));
        check($sformatf("rr%0d_size", k), 160'(str_size), 160'(MIN + (k - 1) % N));
      end
      tick();
    end

    // Reset while string 9 is held
    do_reset();
    valid = m(9); str_ready = 1'b0;
    #1 check("rst9_grant", 160'(ready), 160'(m(9)));
    tick();
    valid = '0;
    #1;
    check("rst9_full", 160'(str_valid), 160'(1));
    check("rst9_size", 160'(str_size), 160'(9));
    tick();
    srst = 1'b1; valid = m(4); str_ready = 1'b1;
    #1 check("rst9_ready_in_reset", 160'(ready), 160'(0));
    tick();
    srst = 1'b0; valid = m(4, 20);
    #1;
    check("rst9_dropped", 160'(str_valid), 160'(0));
    check("rst9_ptr", 160'(ready), 160'(m(4)));
    tick();
    valid = '0;
    #1 check("rst9_next", 160'(str_size), 160'(4));
    tick();

    // Randomized traffic against the model
    do_reset();
    m_ptr = MIN; m_valid = 1'b0; m_size = 0; m_data = '0;
    for (int n = MIN; n <= MAX; n++) begin pend[n] = 0; waits[n] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int g;
      logic load_en;
      for (int n = MIN; n <= MAX; n++) begin
        if (!pend[n] && $urandom_range(0, 3) == 0) begin
          pend[n] = 1; waits[n] = 0;
          for (int b = 0; b < MAX; b++) data_in[n][b] = 8'($urandom);
        end
        valid[n] = pend[n];
      end
      str_ready = ($urandom_range(0, 3) != 0);
      #1;
      load_en = !m_valid || str_ready;
      g = -1;
      if (load_en)
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = MIN + (m_ptr - MIN + k) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      check("rnd_ready", 160'(ready), 160'(m(g)));
      check("rnd_ovalid", 160'(str_valid), 160'(m_valid));
      check("rnd_busy", 160'(busy), 160'(m_valid || (|valid)));
      if (m_valid) begin
        check("rnd_size", 160'(str_size), 160'(m_size));
        check("rnd_data", 160'(str_data), m_data);
      end
      if (g >= 0) begin
        check("rnd_starve", 160'(waits[g] < N), 160'(1));
        for (int n = MIN; n <= MAX; n++)
          if (pend[n] && n != g) waits[n]++;
        m_valid = 1'b1; m_size = g; m_data = padded(g);
        m_ptr = (g == MAX) ? MIN : g + 1;
        pend[g] = 0;
      end else if (load_en) begin
        m_valid = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
